// File: rtl/xnor_frame_checker.sv
// Serial A/B bit-stream comparator: counts mismatches over a FRAME_LEN-bit frame and
// reports done/match at frame end. Define XNOR_FIRST_ERR_EN to capture the first mismatch index.
module xnor_frame_checker #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             valid,
  input  logic             A,
  input  logic             B,
  output logic             ready,
  output logic             busy,
  output logic             Y,
  output logic             done,
  output logic             match,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t           state_q;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             ready_q, busy_q, y_q, done_q, match_q;
  logic             mismatch;
  logic             frame_start;
  logic             accept;

  assign mismatch    = A ^ B;
  assign frame_start = (state_q == S_IDLE) && start && !abort;
  // abort outranks a valid bit in the same cycle
  assign accept      = (state_q == S_RUN) && valid && !abort;
  assign bit_cnt_d   = bit_cnt_q + CNT_W'(1);
  assign err_cnt_d   = err_cnt_q + CNT_W'(mismatch);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      y_q       <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            state_q   <= S_RUN;
            ready_q   <= 1'b1;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
            match_q   <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (valid) begin
            y_q       <= ~mismatch;
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            if (bit_cnt_q == LAST_IDX) begin
              state_q <= S_DONE;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // the verdict only lands if the frame is not aborted in its final cycle
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!abort) match_q <= (err_cnt_q == '0);
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef XNOR_FIRST_ERR_EN
  logic [CNT_W-1:0] first_err_q;

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      first_err_q <= '0;
    end else if (accept && mismatch && (err_cnt_q == '0)) begin
      first_err_q <= bit_cnt_q;
    end
  end

  assign first_err_idx = first_err_q;
`else
  assign first_err_idx = '0;
`endif

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign Y       = y_q;
  assign done    = done_q;
  assign match   = match_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_xnor_frame_checker.sv
// Randomized and directed bench for xnor_frame_checker against a frame-queue reference model.
module tb_xnor_frame_checker;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 4;

  logic clk = 1'b0;
  logic rst, start, abort, valid, A, B;
  logic ready, busy, Y, done, match;
  logic [CNT_W-1:0] err_cnt, first_err_idx;

  xnor_frame_checker #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .valid(valid),
    .A(A), .B(B), .ready(ready), .busy(busy), .Y(Y), .done(done),
    .match(match), .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: phase 0=idle 1=collecting 2=reporting, plus the bits of the frame
  int m_phase = 0;
  bit qa[$];
  bit qb[$];
  bit m_y = 1'b0;
  bit m_match = 1'b0;

  function automatic int m_errs();
    int n = 0;
    foreach (qa[i]) if (qa[i] != qb[i]) n++;
    return n;
  endfunction

  function automatic int m_first();
    foreach (qa[i]) if (qa[i] != qb[i]) return i;
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_phase = 0; qa.delete(); qb.delete(); m_y = 0; m_match = 0;
    end else begin
      case (m_phase)
        0: if (start && !abort) begin
             m_phase = 1; qa.delete(); qb.delete(); m_match = 0;
           end
        1: if (abort) m_phase = 0;
           else if (valid) begin
             qa.push_back(A); qb.push_back(B);
             m_y = (A == B);
             if (qa.size() == FRAME_LEN) m_phase = 2;
           end
        default: begin
          if (!abort) m_match = (m_errs() == 0);
          m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic compare_all();
    check("ready",   ready,   m_phase == 1);
    check("busy",    busy,    m_phase != 0);
    check("done",    done,    m_phase == 2);
    check("Y",       Y,       m_y);
    check("match",   match,   m_match);
    check("err_cnt", err_cnt, m_errs());
`ifdef XNOR_FIRST_ERR_EN
    check("first_err_idx", first_err_idx, m_first());
`else
    check("first_err_idx", first_err_idx, 0);
`endif
  endtask

  task automatic step(input bit r, input bit s, input bit ab, input bit v, input bit a, input bit b);
    rst = r; start = s; abort = ab; valid = v; A = a; B = b;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  // Starts a frame, then feeds the 8 bits MSB first; gaps inserts an idle cycle
  // after every bit. done_k is the index of the step after which done is seen.
  task automatic send_frame(input logic [7:0] fa, input logic [7:0] fb, input bit gaps, output int done_k);
    int j = 0;
    bit v;
    done_k = -1;
    step(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      v = (j < 8) && (!gaps || (k % 2 == 0));
      step(0, 0, 0, v, v ? fa[7-j] : 1'b0, v ? fb[7-j] : 1'b0);
      if (v) j++;
      if (done) begin
        done_k = k;
        break;
      end
    end
    if (done_k < 0) check("done_timeout", 0, 1);
  endtask

  int dk;

  initial begin
    rst = 1; start = 0; abort = 0; valid = 0; A = 0; B = 0;

    // reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_err", err_cnt, 0);
    step(0, 0, 0, 0, 0, 0);

    // equal frame
    send_frame(8'b10110010, 8'b10110010, 0, dk);
    check("t2_latency", dk, 7);
    check("t2_err", err_cnt, 0);
    check("t2_Y", Y, 1);
    step(0, 0, 0, 0, 0, 0);
    check("t2_match", match, 1);
    check("t2_done_gone", done, 0);

    // two mismatches, first at index 2
    send_frame(8'b10110010, 8'b10010011, 0, dk);
    check("t3_err", err_cnt, 2);
    step(0, 0, 0, 0, 0, 0);
    check("t3_match", match, 0);
`ifdef XNOR_FIRST_ERR_EN
    check("t3_first", first_err_idx, 2);
`endif

    // valid toggling: last bit on step 14, done visible 15 cycles after the first bit
    send_frame(8'b10110010, 8'b10110010, 1, dk);
    check("t4_latency", dk, 14);
    step(0, 0, 0, 0, 0, 0);
    check("t4_match", match, 1);
    check("t4_err", err_cnt, 0);

    // abort after 4 bits with one mismatch, abort beats a valid bit
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 1, 0);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_err", err_cnt, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0);
    check("t5_abort_match", match, 0);
    check("t5_abort_nodone", done, 0);

    // rst mid-frame
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 0);
    check("t5_rst_err", err_cnt, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_Y", Y, 0);

    // valid in idle ignored; start during run does not restart the frame
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 1);
    check("t6_idle_err", err_cnt, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    step(0, 1, 0, 1, 1, 0);
    step(0, 1, 0, 1, 1, 1);
    check("t6_run_err", err_cnt, 2);
    check("t6_run_busy", busy, 1);
    step(0, 1, 1, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0,
           1'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
